// File: rtl/ib_vnu_c2v_accum_if.sv
// C2V input channel and sum output channel of the partial-VNU accumulator.
// master = upstream C2V producer / downstream sum consumer, slave = accumulator.
interface ib_vnu_c2v_accum_if #(
    parameter int MSG_WIDTH = 4,
    parameter int CH_WIDTH  = 4,
    parameter int ACC_WIDTH = 7
);
    // Both channels: a transfer happens on a rising clock edge where valid and ready are
    // both high; valid must not depend on ready, and the payload is only meaningful with valid.
    logic                 c2v_valid_i;
    logic                 c2v_ready_o;
    logic [MSG_WIDTH-1:0] c2v_msg_i;
    logic [CH_WIDTH-1:0]  ch_msg_i;
    logic                 sum_valid_o;
    logic                 sum_ready_i;
    logic [ACC_WIDTH-1:0] sum_o;
    logic                 hard_dec_o;

    modport master (
        output c2v_valid_i, c2v_msg_i, ch_msg_i, sum_ready_i,
        input  c2v_ready_o, sum_valid_o, sum_o, hard_dec_o
    );

    modport slave (
        input  c2v_valid_i, c2v_msg_i, ch_msg_i, sum_ready_i,
        output c2v_ready_o, sum_valid_o, sum_o, hard_dec_o
    );
endinterface

// File: rtl/ib_vnu_c2v_accum.sv
// Partial-VNU accumulator: sums the channel value and VN_DEG sign-magnitude C2V beats
// into a symmetric saturating two's-complement total, then offers it with its hard decision.
module ib_vnu_c2v_accum #(
    parameter int MSG_WIDTH = 4,
    parameter int CH_WIDTH  = 4,
    parameter int VN_DEG    = 3,
    parameter int ACC_WIDTH = 7
) (
    input  logic                  sys_clk,
    input  logic                  rstn,
    input  logic                  flush_i,
    ib_vnu_c2v_accum_if.slave     bus,
    output logic [1:0]            state_o
);
    localparam int CW = $clog2(VN_DEG + 1);

    localparam logic signed [ACC_WIDTH:0] SMAX =
        $signed((ACC_WIDTH+1)'((1 << (ACC_WIDTH - 1)) - 1));
    localparam logic signed [ACC_WIDTH:0] SMIN = -SMAX;
    localparam logic [ACC_WIDTH-1:0] POS_MAX  = SMAX[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] NEG_MAX  = SMIN[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] NEG_FULL = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic                 rdy_q, rdy_d;
    logic                 vld_q, vld_d;

    logic                 beat;
    logic [ACC_WIDTH-1:0] c2v_val;
    logic [ACC_WIDTH-1:0] ch_val;
    logic [ACC_WIDTH-1:0] mag_ext;

    // The +/-(2^(ACC_WIDTH-1)-1) range keeps the sum symmetric so negation never overflows.
    function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] x,
                                                     input logic [ACC_WIDTH-1:0] y);
        logic signed [ACC_WIDTH:0] s;
        s = $signed({x[ACC_WIDTH-1], x}) + $signed({y[ACC_WIDTH-1], y});
        if (s > SMAX)      return POS_MAX;
        else if (s < SMIN) return NEG_MAX;
        else               return s[ACC_WIDTH-1:0];
    endfunction

    assign beat    = bus.c2v_valid_i & rdy_q;
    assign mag_ext = ACC_WIDTH'(bus.c2v_msg_i[MSG_WIDTH-2:0]);
    assign c2v_val = bus.c2v_msg_i[MSG_WIDTH-1] ? (-mag_ext) : mag_ext;

    always_comb begin
        ch_val = ACC_WIDTH'($signed(bus.ch_msg_i));
        if (ch_val == NEG_FULL) ch_val = NEG_MAX;
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat) begin
                        acc_d = sat_add(ch_val, c2v_val);
                        if (VN_DEG == 1) begin
                            cnt_d   = '0;
                            state_d = OUT;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_d = sat_add(acc_q, c2v_val);
                        if (cnt_q == CW'(VN_DEG - 1)) begin
                            cnt_d   = '0;
                            state_d = OUT;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                OUT: begin
                    if (bus.sum_ready_i) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state, so ready never sees sum_ready_i combinationally.
    always_comb begin
        rdy_d = (state_d == IDLE) || (state_d == ACCUM);
        vld_d = (state_d == OUT);
        sum_d = (state_d == OUT) ? acc_d : sum_q;
    end

    assign bus.c2v_ready_o = rdy_q;
    assign bus.sum_valid_o = vld_q;
    assign bus.sum_o       = sum_q;
    assign bus.hard_dec_o  = sum_q[ACC_WIDTH-1];
    assign state_o         = state_q;

endmodule

// File: tb/tb_ib_vnu_c2v_accum.sv
// Directed bench for ib_vnu_c2v_accum: default, ACC_WIDTH=5 and VN_DEG=1 instances.
module tb_ib_vnu_c2v_accum;
    logic sys_clk = 1'b0;
    logic rstn    = 1'b0;
    logic flush_a = 1'b0;
    logic flush_off = 1'b0;
    logic [1:0] st_a, st_b, st_c;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    ib_vnu_c2v_accum_if #(.MSG_WIDTH(4), .CH_WIDTH(4), .ACC_WIDTH(7)) a ();
    ib_vnu_c2v_accum_if #(.MSG_WIDTH(4), .CH_WIDTH(4), .ACC_WIDTH(5)) b ();
    ib_vnu_c2v_accum_if #(.MSG_WIDTH(4), .CH_WIDTH(4), .ACC_WIDTH(7)) c ();

    ib_vnu_c2v_accum #(.MSG_WIDTH(4), .CH_WIDTH(4), .VN_DEG(3), .ACC_WIDTH(7)) u_a (
        .sys_clk(sys_clk), .rstn(rstn), .flush_i(flush_a), .bus(a), .state_o(st_a));
    ib_vnu_c2v_accum #(.MSG_WIDTH(4), .CH_WIDTH(4), .VN_DEG(3), .ACC_WIDTH(5)) u_b (
        .sys_clk(sys_clk), .rstn(rstn), .flush_i(flush_off), .bus(b), .state_o(st_b));
    ib_vnu_c2v_accum #(.MSG_WIDTH(4), .CH_WIDTH(4), .VN_DEG(1), .ACC_WIDTH(7)) u_c (
        .sys_clk(sys_clk), .rstn(rstn), .flush_i(flush_off), .bus(c), .state_o(st_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Presents one beat on instance w for exactly one edge; the caller knows ready is high.
    task automatic beat(input int w, input logic [3:0] m);
        case (w)
            0: begin chk("a_ready_before_beat", a.c2v_ready_o, 1); a.c2v_valid_i = 1'b1; a.c2v_msg_i = m; end
            1: begin chk("b_ready_before_beat", b.c2v_ready_o, 1); b.c2v_valid_i = 1'b1; b.c2v_msg_i = m; end
            default: begin chk("c_ready_before_beat", c.c2v_ready_o, 1); c.c2v_valid_i = 1'b1; c.c2v_msg_i = m; end
        endcase
        tick();
        a.c2v_valid_i = 1'b0;
        b.c2v_valid_i = 1'b0;
        c.c2v_valid_i = 1'b0;
    endtask

    task automatic release_sum(input int w);
        case (w)
            0: a.sum_ready_i = 1'b1;
            1: b.sum_ready_i = 1'b1;
            default: c.sum_ready_i = 1'b1;
        endcase
        tick();
        a.sum_ready_i = 1'b0;
        b.sum_ready_i = 1'b0;
        c.sum_ready_i = 1'b0;
    endtask

    initial begin
        a.c2v_valid_i = 0; a.c2v_msg_i = 0; a.ch_msg_i = 0; a.sum_ready_i = 0;
        b.c2v_valid_i = 0; b.c2v_msg_i = 0; b.ch_msg_i = 0; b.sum_ready_i = 0;
        c.c2v_valid_i = 0; c.c2v_msg_i = 0; c.ch_msg_i = 0; c.sum_ready_i = 0;

        // Reset values
        #2;
        chk("rst_ready", a.c2v_ready_o, 0);
        chk("rst_valid", a.sum_valid_o, 0);
        chk("rst_sum", a.sum_o, 0);
        chk("rst_hard", a.hard_dec_o, 0);
        chk("rst_state", st_a, 0);
        #5 rstn = 1'b1;
        tick();
        chk("ready_after_release", a.c2v_ready_o, 1);
        chk("c_ready_after_release", c.c2v_ready_o, 1);

        // 1: basic, ch=+3, beats +2,-5,+1 -> +1
        a.ch_msg_i = 4'b0011;
        beat(0, 4'b0010);
        a.ch_msg_i = 4'b0111;
        beat(0, 4'b1101);
        chk("t1_valid_early", a.sum_valid_o, 0);
        beat(0, 4'b0001);
        chk("t1_valid", a.sum_valid_o, 1);
        chk("t1_sum", a.sum_o, 7'h01);
        chk("t1_hard", a.hard_dec_o, 0);
        chk("t1_ready_in_out", a.c2v_ready_o, 0);
        release_sum(0);
        chk("t1_valid_drop", a.sum_valid_o, 0);
        chk("t1_ready_back", a.c2v_ready_o, 1);
        chk("t1_state_idle", st_a, 0);

        // 2: saturation on the 5-bit instance
        b.ch_msg_i = 4'b0111;
        beat(1, 4'b0111);
        beat(1, 4'b0111);
        beat(1, 4'b0111);
        chk("t2_pos_valid", b.sum_valid_o, 1);
        chk("t2_pos_sum", b.sum_o, 5'h0F);
        chk("t2_pos_hard", b.hard_dec_o, 0);
        release_sum(1);
        b.ch_msg_i = 4'b1000;
        beat(1, 4'b1111);
        beat(1, 4'b1111);
        beat(1, 4'b1111);
        chk("t2_neg_sum", b.sum_o, 5'h11);
        chk("t2_neg_hard", b.hard_dec_o, 1);
        release_sum(1);

        // 3: backpressure, ch=-1, beats +2,+2,+1 -> +4
        a.ch_msg_i = 4'b1111;
        beat(0, 4'b0010);
        beat(0, 4'b0010);
        beat(0, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            a.c2v_valid_i = 1'b1;
            a.c2v_msg_i = 4'b0111;
            chk("t3_ready_low", a.c2v_ready_o, 0);
            chk("t3_valid_held", a.sum_valid_o, 1);
            chk("t3_sum_held", a.sum_o, 7'h04);
            tick();
        end
        a.c2v_valid_i = 1'b0;
        chk("t3_sum_after_hold", a.sum_o, 7'h04);
        release_sum(0);
        chk("t3_state_idle", st_a, 0);
        chk("t3_valid_drop", a.sum_valid_o, 0);
        chk("t3_sum_kept", a.sum_o, 7'h04);

        // 4: bubbles 1,0,0,1,0,1 with negative zero, ch=0 -> 0
        a.ch_msg_i = 4'b0000;
        beat(0, 4'b1000);
        a.c2v_msg_i = 4'b0111;
        tick();
        tick();
        chk("t4_valid_bubble", a.sum_valid_o, 0);
        beat(0, 4'b0011);
        a.c2v_msg_i = 4'b0111;
        tick();
        chk("t4_valid_before_last", a.sum_valid_o, 0);
        chk("t4_state_accum", st_a, 1);
        beat(0, 4'b1011);
        chk("t4_valid", a.sum_valid_o, 1);
        chk("t4_sum", a.sum_o, 7'h00);
        chk("t4_hard", a.hard_dec_o, 0);
        release_sum(0);

        // 5: flush with the 2nd beat, then ch=+1, beats +1,+1,+1 -> +4
        a.ch_msg_i = 4'b0101;
        beat(0, 4'b0010);
        flush_a = 1'b1;
        a.c2v_valid_i = 1'b1;
        a.c2v_msg_i = 4'b0011;
        tick();
        flush_a = 1'b0;
        a.c2v_valid_i = 1'b0;
        chk("t5_state_idle", st_a, 0);
        chk("t5_valid", a.sum_valid_o, 0);
        a.ch_msg_i = 4'b0001;
        beat(0, 4'b0001);
        beat(0, 4'b0001);
        beat(0, 4'b0001);
        chk("t5_sum", a.sum_o, 7'h04);
        chk("t5_valid_out", a.sum_valid_o, 1);
        release_sum(0);

        // 6: async reset mid-ACCUM, then VN_DEG=1 instance
        a.ch_msg_i = 4'b0010;
        beat(0, 4'b0001);
        chk("t6_state_accum", st_a, 1);
        #3 rstn = 1'b0;
        #1;
        chk("t6_rst_ready", a.c2v_ready_o, 0);
        chk("t6_rst_state", st_a, 0);
        chk("t6_rst_sum", a.sum_o, 0);
        chk("t6_rst_valid", a.sum_valid_o, 0);
        #2 rstn = 1'b1;
        tick();
        chk("t6_ready_after", a.c2v_ready_o, 1);
        c.ch_msg_i = 4'b1110;
        beat(2, 4'b0001);
        chk("t6c_valid", c.sum_valid_o, 1);
        chk("t6c_sum", c.sum_o, 7'h7F);
        chk("t6c_hard", c.hard_dec_o, 1);
        chk("t6c_state_out", st_c, 2);
        release_sum(2);
        chk("t6c_valid_drop", c.sum_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
